// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the instruction decode controller.
//   - opcode and ALU_1 subop encodings
//   - alu_op_e : ALU operation driven to the datapath
//   - state_e  : sequencing FSM states
package decode_pkg;

    // Opcodes, instruction bits [30:25]
    localparam logic [5:0] OpAlu1 = 6'b100000;
    localparam logic [5:0] OpAddi = 6'b101000;
    localparam logic [5:0] OpOri  = 6'b101100;
    localparam logic [5:0] OpXori = 6'b101011;
    localparam logic [5:0] OpMovi = 6'b100010;

    // ALU_1 subops, instruction bits [4:0]
    localparam logic [4:0] SubAdd   = 5'b00000;
    localparam logic [4:0] SubSub   = 5'b00001;
    localparam logic [4:0] SubAnd   = 5'b00010;
    localparam logic [4:0] SubXor   = 5'b00011;
    localparam logic [4:0] SubOr    = 5'b00100;
    localparam logic [4:0] SubSlli  = 5'b01000;
    localparam logic [4:0] SubRotri = 5'b01011;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluRotr,
        AluMov
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback
    } state_e;

endpackage

// File: rtl/imm_ext.sv
// imm_ext: combinational immediate selection and sign/zero extension.
// Ports:
//   i_opcode [5:0]          instruction opcode field
//   i_subop  [4:0]          ALU_1 subop field
//   i_field  [19:0]         instruction bits [19:0]
//   o_imm    [DataSize-1:0] extended immediate, 0 for non-immediate or unknown encodings
module imm_ext
    import decode_pkg::*;
#(
    parameter int unsigned DataSize = 32
) (
    input  logic [5:0]          i_opcode,
    input  logic [4:0]          i_subop,
    input  logic [19:0]         i_field,
    output logic [DataSize-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_opcode)
            OpAlu1: begin
                // Only the shift/rotate subops carry an immediate (imm5 in [14:10])
                if (i_subop == SubSlli || i_subop == SubRotri) begin
                    o_imm = {{(DataSize-5){1'b0}}, i_field[14:10]};
                end
            end
            OpAddi: o_imm = {{(DataSize-15){i_field[14]}}, i_field[14:0]};
            OpOri,
            OpXori: o_imm = {{(DataSize-15){1'b0}}, i_field[14:0]};
            OpMovi: o_imm = {{(DataSize-20){i_field[19]}}, i_field[19:0]};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: multi-cycle instruction decode and sequencing controller.
// One instruction completes every 4 clocks: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Ports:
//   clk, reset (async, active-low)
//   instruction       instruction word, captured on the FETCH->DECODE edge
//   enable_fetch      high in FETCH
//   enable_execute    high in EXECUTE
//   enable_writeback  high in WRITEBACK for a legal instruction
//   alu_op, imm_sel, imm, read_address1/2, write_address, illegal
//                     decode outputs, registered on the DECODE->EXECUTE edge
//   retired_cnt       number of legal instructions written back (wraps)
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned DataSize = 32,
    parameter int unsigned AddrSize = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DataSize-1:0] instruction,
    output logic                enable_fetch,
    output logic                enable_execute,
    output logic                enable_writeback,
    output alu_op_e             alu_op,
    output logic                imm_sel,
    output logic [DataSize-1:0] imm,
    output logic [AddrSize-1:0] read_address1,
    output logic [AddrSize-1:0] read_address2,
    output logic [AddrSize-1:0] write_address,
    output logic                illegal,
    output logic [15:0]         retired_cnt
);

    state_e              r_state;
    logic [DataSize-1:0] r_instr;
    logic                r_enable_fetch;
    logic                r_enable_execute;
    logic                r_enable_writeback;
    alu_op_e             r_alu_op;
    logic                r_imm_sel;
    logic [DataSize-1:0] r_imm;
    logic [AddrSize-1:0] r_read_address1;
    logic [AddrSize-1:0] r_read_address2;
    logic [AddrSize-1:0] r_write_address;
    logic                r_illegal;
    logic [15:0]         r_retired_cnt;

    logic [5:0]          w_opcode;
    logic [4:0]          w_subop;
    logic [DataSize-1:0] w_imm_ext;
    alu_op_e             w_alu_op;
    logic                w_imm_sel;
    logic                w_illegal;

    assign w_opcode = r_instr[30:25];
    assign w_subop  = r_instr[4:0];

    imm_ext #(
        .DataSize(DataSize)
    ) u_imm_ext (
        .i_opcode(w_opcode),
        .i_subop (w_subop),
        .i_field (r_instr[19:0]),
        .o_imm   (w_imm_ext)
    );

    // Decode of the latched word; an illegal word falls back to ADD with imm_sel 0.
    always_comb begin
        w_alu_op  = AluAdd;
        w_imm_sel = 1'b0;
        w_illegal = 1'b0;
        if (r_instr[31]) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OpAlu1: begin
                    case (w_subop)
                        SubAdd:   w_alu_op = AluAdd;
                        SubSub:   w_alu_op = AluSub;
                        SubAnd:   w_alu_op = AluAnd;
                        SubXor:   w_alu_op = AluXor;
                        SubOr:    w_alu_op = AluOr;
                        SubSlli: begin
                            w_alu_op  = AluSll;
                            w_imm_sel = 1'b1;
                        end
                        SubRotri: begin
                            w_alu_op  = AluRotr;
                            w_imm_sel = 1'b1;
                        end
                        default:  w_illegal = 1'b1;
                    endcase
                end
                OpAddi: begin
                    w_alu_op  = AluAdd;
                    w_imm_sel = 1'b1;
                end
                OpOri: begin
                    w_alu_op  = AluOr;
                    w_imm_sel = 1'b1;
                end
                OpXori: begin
                    w_alu_op  = AluXor;
                    w_imm_sel = 1'b1;
                end
                OpMovi: begin
                    w_alu_op  = AluMov;
                    w_imm_sel = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
            if (w_illegal) begin
                w_alu_op  = AluAdd;
                w_imm_sel = 1'b0;
            end
        end
    end

    // Sequencer. Enables are registered against the state being entered so they
    // are clean Moore outputs aligned with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= StIdle;
            r_instr            <= '0;
            r_enable_fetch     <= 1'b0;
            r_enable_execute   <= 1'b0;
            r_enable_writeback <= 1'b0;
            r_alu_op           <= AluAdd;
            r_imm_sel          <= 1'b0;
            r_imm              <= '0;
            r_read_address1    <= '0;
            r_read_address2    <= '0;
            r_write_address    <= '0;
            r_illegal          <= 1'b0;
            r_retired_cnt      <= '0;
        end else begin
            r_enable_fetch     <= 1'b0;
            r_enable_execute   <= 1'b0;
            r_enable_writeback <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_state        <= StFetch;
                    r_enable_fetch <= 1'b1;
                end
                StFetch: begin
                    r_instr <= instruction;
                    r_state <= StDecode;
                end
                StDecode: begin
                    r_alu_op         <= w_alu_op;
                    r_imm_sel        <= w_imm_sel;
                    r_imm            <= w_illegal ? '0 : w_imm_ext;
                    r_read_address1  <= r_instr[19:15];
                    r_read_address2  <= r_instr[14:10];
                    r_write_address  <= r_instr[24:20];
                    r_illegal        <= w_illegal;
                    r_state          <= StExecute;
                    r_enable_execute <= 1'b1;
                end
                StExecute: begin
                    r_state            <= StWriteback;
                    r_enable_writeback <= !r_illegal;
                end
                StWriteback: begin
                    if (!r_illegal) begin
                        r_retired_cnt <= r_retired_cnt + 16'd1;
                    end
                    r_state        <= StFetch;
                    r_enable_fetch <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign enable_fetch     = r_enable_fetch;
    assign enable_execute   = r_enable_execute;
    assign enable_writeback = r_enable_writeback;
    assign alu_op           = r_alu_op;
    assign imm_sel          = r_imm_sel;
    assign imm              = r_imm;
    assign read_address1    = r_read_address1;
    assign read_address2    = r_read_address2;
    assign write_address    = r_write_address;
    assign illegal          = r_illegal;
    assign retired_cnt      = r_retired_cnt;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: scoreboard bench for decode_ctrl. Expected decode results are
// produced by a bench-side model when a word is driven in FETCH and compared when
// the DUT reaches EXECUTE.
module tb_decode_ctrl;

    logic                  clk;
    logic                  reset;
    logic [31:0]           instruction;
    logic                  enable_fetch;
    logic                  enable_execute;
    logic                  enable_writeback;
    decode_pkg::alu_op_e   alu_op;
    logic                  imm_sel;
    logic [31:0]           imm;
    logic [4:0]            read_address1;
    logic [4:0]            read_address2;
    logic [4:0]            write_address;
    logic                  illegal;
    logic [15:0]           retired_cnt;

    decode_ctrl #(
        .DataSize(32),
        .AddrSize(5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction     (instruction),
        .enable_fetch    (enable_fetch),
        .enable_execute  (enable_execute),
        .enable_writeback(enable_writeback),
        .alu_op          (alu_op),
        .imm_sel         (imm_sel),
        .imm             (imm),
        .read_address1   (read_address1),
        .read_address2   (read_address2),
        .write_address   (write_address),
        .illegal         (illegal),
        .retired_cnt     (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ALU op codes, in the order the operation enum lists them
    localparam logic [3:0] EAdd = 4'd0, ESub = 4'd1, EAnd = 4'd2, EOr = 4'd3;
    localparam logic [3:0] EXor = 4'd4, ESll = 4'd5, ERotr = 4'd6, EMov = 4'd7;

    typedef struct {
        logic [3:0]  op;
        logic        sel;
        logic [31:0] imm;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rt;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e.op  = EAdd;
        e.sel = 1'b0;
        e.imm = '0;
        e.ill = 1'b0;
        e.rt  = w[24:20];
        e.ra  = w[19:15];
        e.rb  = w[14:10];
        if (w[31]) begin
            e.ill = 1'b1;
        end else begin
            case (w[30:25])
                6'b100000: begin
                    case (w[4:0])
                        5'd0:  e.op = EAdd;
                        5'd1:  e.op = ESub;
                        5'd2:  e.op = EAnd;
                        5'd3:  e.op = EXor;
                        5'd4:  e.op = EOr;
                        5'd8:  begin e.op = ESll;  e.sel = 1'b1; e.imm = {27'd0, w[14:10]}; end
                        5'd11: begin e.op = ERotr; e.sel = 1'b1; e.imm = {27'd0, w[14:10]}; end
                        default: e.ill = 1'b1;
                    endcase
                end
                6'b101000: begin e.op = EAdd; e.sel = 1'b1; e.imm = {{17{w[14]}}, w[14:0]}; end
                6'b101100: begin e.op = EOr;  e.sel = 1'b1; e.imm = {17'd0, w[14:0]}; end
                6'b101011: begin e.op = EXor; e.sel = 1'b1; e.imm = {17'd0, w[14:0]}; end
                6'b100010: begin e.op = EMov; e.sel = 1'b1; e.imm = {{12{w[19]}}, w[19:0]}; end
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) begin
            e.op  = EAdd;
            e.sel = 1'b0;
            e.imm = '0;
        end
        return e;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [14:0] imm15);
        return {1'b0, opc, rt, ra, imm15};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rt, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [4:0] sub);
        return {1'b0, 6'b100000, rt, ra, rb, 5'd0, sub};
    endfunction

    // Bounded wait for FETCH, sampled on the falling edge
    task automatic wait_fetch();
        int n;
        n = 0;
        while (enable_fetch !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (enable_fetch !== 1'b1) check_eq("fetch_timeout", 32'(enable_fetch), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en_f"},  32'(enable_fetch), 32'd0);
        check_eq({tag, "_en_x"},  32'(enable_execute), 32'd0);
        check_eq({tag, "_en_wb"}, 32'(enable_writeback), 32'd0);
        check_eq({tag, "_aluop"}, 32'(alu_op), 32'd0);
        check_eq({tag, "_isel"},  32'(imm_sel), 32'd0);
        check_eq({tag, "_imm"},   imm, 32'd0);
        check_eq({tag, "_addr"},  32'({read_address1, read_address2, write_address}), 32'd0);
        check_eq({tag, "_ill"},   32'(illegal), 32'd0);
        check_eq({tag, "_cnt"},   32'(retired_cnt), 32'd0);
    endtask

    // Called on a falling edge while in FETCH; returns on the falling edge of the next FETCH.
    task automatic run_instr(input logic [31:0] w);
        exp_t e;
        exp_t got;
        check_eq("in_fetch", 32'(enable_fetch), 32'd1);
        instruction = w;
        sb.push_back(model(w));
        @(negedge clk);                       // DECODE
        instruction = $urandom;               // must be ignored
        @(negedge clk);                       // EXECUTE
        check_eq("en_execute", 32'(enable_execute), 32'd1);
        check_eq("en_fetch_off", 32'(enable_fetch), 32'd0);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("alu_op", 32'(alu_op), 32'(e.op));
        check_eq("imm_sel", 32'(imm_sel), 32'(e.sel));
        check_eq("imm", imm, e.imm);
        check_eq("ra", 32'(read_address1), 32'(e.ra));
        check_eq("rb", 32'(read_address2), 32'(e.rb));
        check_eq("rt", 32'(write_address), 32'(e.rt));
        check_eq("illegal", 32'(illegal), 32'(e.ill));
        got = e;
        instruction = $urandom;
        @(negedge clk);                       // WRITEBACK
        check_eq("en_writeback", 32'(enable_writeback), 32'(!got.ill));
        check_eq("hold_wb_op", 32'(alu_op), 32'(got.op));
        check_eq("hold_wb_imm", imm, got.imm);
        check_eq("hold_wb_ill", 32'(illegal), 32'(got.ill));
        if (!got.ill) model_cnt = model_cnt + 16'd1;
        instruction = $urandom;
        @(negedge clk);                       // FETCH again: exactly 4 clocks
        check_eq("wb_pulse", 32'(enable_writeback), 32'd0);
        check_eq("retired_cnt", 32'(retired_cnt), 32'(model_cnt));
        check_eq("hold_fetch_imm", imm, got.imm);
    endtask

    logic [31:0] prog[$];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        instruction = '0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");

        reset = 1'b1;
        @(negedge clk);
        check_eq("fetch_after_rst", 32'(enable_fetch), 32'd1);

        // Basic ADDI, imm 13
        run_instr(enc_i(6'b101000, 5'd0, 5'd0, 15'd13));
        check_eq("cnt_after_addi", 32'(retired_cnt), 32'd1);

        // Reset mid-EXECUTE clears everything at once
        instruction = enc_i(6'b100010, 5'd7, 5'd0, 15'h1234);
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_x_state", 32'(enable_execute), 32'd1);
        #1 reset = 1'b0;
        #1 check_all_zero("abort_x");
        @(negedge clk);
        reset = 1'b1;
        model_cnt = '0;
        @(negedge clk);
        check_eq("fetch_after_abort", 32'(enable_fetch), 32'd1);

        prog.push_back(enc_i(6'b100010, 5'd2, 5'd0, 15'd0) | 32'h0008_0000); // MOVI 0x80000
        prog.push_back(enc_i(6'b101100, 5'd3, 5'd4, 15'h4000));              // ORI
        prog.push_back(enc_i(6'b101011, 5'd5, 5'd6, 15'h7FFF));              // XORI
        prog.push_back(enc_i(6'b101000, 5'd9, 5'd10, 15'h4001));             // ADDI negative
        prog.push_back(enc_r(5'd1, 5'd2, 5'd3, 5'd1));                       // SUB
        prog.push_back(enc_r(5'd4, 5'd5, 5'd6, 5'd2));                       // AND
        prog.push_back(enc_r(5'd7, 5'd8, 5'd9, 5'd4));                       // OR
        prog.push_back(enc_r(5'd10, 5'd11, 5'd12, 5'd3));                    // XOR
        prog.push_back(enc_r(5'd13, 5'd14, 5'd4, 5'd8));                     // SLLI 4
        prog.push_back(enc_r(5'd15, 5'd16, 5'd8, 5'd11));                    // ROTRI 8
        prog.push_back(32'h8000_0000);                                       // bit 31 set
        prog.push_back(enc_i(6'b111111, 5'd1, 5'd1, 15'd5));                 // bad opcode
        prog.push_back(enc_r(5'd1, 5'd1, 5'd1, 5'd31));                      // bad subop
        prog.push_back(enc_r(5'd31, 5'd30, 5'd29, 5'd0));                    // ADD
        foreach (prog[i]) run_instr(prog[i]);
        check_eq("cnt_after_prog", 32'(retired_cnt), 32'd11);

        // Reset mid-WRITEBACK: no write enable survives, counter clears
        instruction = enc_r(5'd1, 5'd2, 5'd3, 5'd0);
        repeat (3) @(negedge clk);
        check_eq("abort_wb_state", 32'(enable_writeback), 32'd1);
        #1 reset = 1'b0;
        #1 check_all_zero("abort_wb");
        @(negedge clk);
        reset = 1'b1;
        model_cnt = '0;
        @(negedge clk);
        wait_fetch();

        // Counter wrap: preload 0xFFFF while in FETCH
        force dut.r_retired_cnt = 16'hFFFF;
        #1 release dut.r_retired_cnt;
        model_cnt = 16'hFFFF;
        check_eq("preload", 32'(retired_cnt), 32'hFFFF);
        run_instr(enc_i(6'b101000, 5'd1, 5'd2, 15'd1));
        check_eq("wrap", 32'(retired_cnt), 32'h0000);
        run_instr(enc_i(6'b101100, 5'd1, 5'd2, 15'd2));

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Multi-cycle instruction decode and sequencing controller for the datapath (register file + ALU) inside `top`. Each instruction is latched from the `instruction` bus, decoded into register addresses, an ALU operation and an extended immediate, then sequenced through a fixed four-state cycle. The controller drives the datapath enables, so one instruction completes every 4 clocks.

## Interface
- `DataSize`, 32, instruction and immediate width
- `AddrSize`, 5, register address width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; `reset`=0 forces the reset state immediately
- `instruction`  in  DataSize  instruction word, sampled in FETCH only
- `enable_fetch`  out  1  high while in FETCH
- `enable_execute`  out  1  high while in EXECUTE
- `enable_writeback`  out  1  high while in WRITEBACK, and only for a legal instruction
- `alu_op`  out  4  decoded ALU operation (package enum)
- `imm_sel`  out  1  ALU operand 2 source: 1 = `imm`, 0 = register `rb`
- `imm`  out  DataSize  extended immediate
- `read_address1`  out  AddrSize  `ra` field
- `read_address2`  out  AddrSize  `rb` field
- `write_address`  out  AddrSize  `rt` field
- `illegal`  out  1  held high from EXECUTE through WRITEBACK for an undecodable word
- `retired_cnt`  out  16  count of legal instructions written back

## Operation
- Field map: [31] must be 0; [30:25] opcode; [24:20] rt; [19:15] ra; [14:10] rb/imm5; [4:0] subop.
- Opcode 100000 (ALU_1), subop selects the operation:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 XOR, 00100 OR: `imm_sel`=0
  - 01000 SLLI, 01011 ROTRI: `imm_sel`=1; `imm` = zero-extended [14:10]
- Opcode 101000 ADDI: ADD, `imm` = sign-extended [14:0], `imm_sel`=1.
- Opcode 101100 ORI and 101011 XORI: `imm` = zero-extended [14:0], `imm_sel`=1.
- Opcode 100010 MOVI: op MOV (result = operand 2). `imm` = sign-extended [19:0], `imm_sel`=1.
- Illegal: bit 31 = 1, any other opcode, or any other subop under ALU_1. For an illegal word: `alu_op`=ADD, `imm`=0, no writeback enable, `retired_cnt` unchanged.
- FSM states: IDLE → FETCH → DECODE → EXECUTE → WRITEBACK → FETCH (unconditional). IDLE is entered only from reset.
- `retired_cnt` increments by 1 on the WRITEBACK→FETCH edge for a legal instruction. It wraps 0xFFFF → 0.

## Timing
- Reset values: state IDLE; every output 0, including `retired_cnt` and the latched instruction.
- After `reset` rises: first clock edge gives IDLE→FETCH.
- `instruction` is captured on the FETCH→DECODE edge. Changes to the bus at any other time are ignored.
- Decode outputs (`alu_op`, `imm_sel`, `imm`, addresses, `illegal`) are registered on the DECODE→EXECUTE edge. They stay stable through EXECUTE and WRITEBACK, and until the next DECODE→EXECUTE edge.
- State enables are Moore outputs, registered, with no glitches.
- Latency: instruction sampled at edge N; `enable_writeback` is high during the cycle after edge N+2. The register file writes at edge N+3.
- `reset` low in any state (including mid-WRITEBACK) aborts immediately: no write enable is produced, and the counter clears.

## Structure
- Package `decode_pkg` holds:
  - opcode constants (ALU_1, ADDI, ORI, XORI, MOVI)
  - subop constants
  - the `alu_op` enum: ADD, SUB, AND, OR, XOR, SLL, ROTR, MOV
  - the FSM state enum
- One sub-module, `imm_ext`: combinational immediate selection and sign/zero extension, driven by opcode and subop.
- The FSM, instruction register, decode registers and counter live in `decode_ctrl`.

## Test plan
- Reset: `reset`=0 mid-EXECUTE → all outputs 0 immediately. After release, `enable_fetch` is high 1 clock later.
- ADDI 0_101000_00000_00000_000000000001101 → `write_address`=0, `read_address1`=0, `alu_op`=ADD, `imm_sel`=1, `imm`=13. `enable_writeback` pulses 1 cycle; `retired_cnt`=1.
- MOVI rt=2, imm20=0x80000 → `alu_op`=MOV, `imm`=0xFFF80000. ORI with imm15=0x4000 → `imm`=0x00004000, with no sign extension.
- ALU_1 sequence SUB, AND, OR, XOR, SLLI (imm5=4), ROTRI (imm5=8) → correct `alu_op` each time. `imm_sel`=0 for the first four, and `imm_sel`=1 with `imm`=4 and 8 for the shifts. Exactly 4 clocks per instruction.
- Illegal words: 0x80000000, opcode 111111, and ALU_1 subop 11111 → `illegal`=1, `enable_writeback` stays 0, `retired_cnt` unchanged. The next legal word decodes normally.
- Preload via 65536 legal instructions (or a force) → `retired_cnt` wraps 0xFFFF → 0x0000. Toggling `instruction` outside FETCH has no effect on the decode outputs.
